riscv_id_stage: RTL

RISCV_ID_STAGE -- requirements
Module: riscv_id_stage

---
 rtl/riscv_constants.sv | 120 ++++++++++++
 rtl/riscv_decoder.sv | 133 +++++++++++++
 rtl/riscv_id_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_constants.sv
// Shared RV32I decode constants, ALU/writeback encodings and the decoded-instruction bundle
// used by the decode stage and its combinational decoder.
package riscv_constants;

  localparam int unsigned XLEN = 32;

  typedef enum logic [4:0] {
    ALU_X,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_BEQ,
    ALU_BNE,
    ALU_BLT,
    ALU_BGE,
    ALU_BLTU,
    ALU_BGEU,
    ALU_JALR
  } EXEC_FUN;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } WB_SEL;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    EXEC_FUN     exec_fun;
    WB_SEL       wb_sel;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] store_data;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        rf_wen;
    logic        mem_wen;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } id_bundle_t;

  function automatic id_bundle_t idle_bundle();
    id_bundle_t b;
    b          = '0;
    b.exec_fun = ALU_X;
    b.wb_sel   = WB_ALU;
    return b;
  endfunction

  // ALU_X flags an unsupported funct3/funct7 combination for OP and OP-IMM.
  function automatic EXEC_FUN alu_op(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic is_reg);
    logic base;
    logic alt;
    EXEC_FUN fun;
    base = (f7 == F7_BASE);
    alt  = (f7 == F7_ALT);
    fun  = ALU_X;
    case (f3)
      F3_ADD_SUB: begin
        if (!is_reg || base) fun = ALU_ADD;
        else if (alt)        fun = ALU_SUB;
      end
      F3_SLL:     if (base) fun = ALU_SLL;
      F3_SLT:     if (!is_reg || base) fun = ALU_SLT;
      F3_SLTU:    if (!is_reg || base) fun = ALU_SLTU;
      F3_XOR:     if (!is_reg || base) fun = ALU_XOR;
      F3_SRL_SRA: begin
        if (base)     fun = ALU_SRL;
        else if (alt) fun = ALU_SRA;
      end
      F3_OR:      if (!is_reg || base) fun = ALU_OR;
      F3_AND:     if (!is_reg || base) fun = ALU_AND;
      default:    fun = ALU_X;
    endcase
    return fun;
  endfunction

endpackage

// File: rtl/riscv_decoder.sv
// Combinational RV32I decoder: instruction word, pc and register read data in,
// control flags and ALU operands out.
module riscv_decoder
  import riscv_constants::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output id_bundle_t      dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        legal;

  assign opcode   = inst[6:0];
  assign rd       = inst[11:7];
  assign funct3   = inst[14:12];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign funct7   = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec         = idle_bundle();
    dec.pc      = pc;
    dec.rd_addr = rd;
    legal       = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.exec_fun = alu_op(funct3, funct7, 1'b1);
        dec.data1    = rs1_data;
        dec.data2    = rs2_data;
        dec.rf_wen   = 1'b1;
        legal        = (dec.exec_fun != ALU_X);
      end
      OPC_OP_IMM: begin
        dec.exec_fun = alu_op(funct3, funct7, 1'b0);
        dec.data1    = rs1_data;
        dec.data2    = (funct3 == F3_SLL || funct3 == F3_SRL_SRA) ?
                       {27'b0, inst[24:20]} : imm_i;
        dec.rf_wen   = 1'b1;
        legal        = (dec.exec_fun != ALU_X);
      end
      OPC_LUI: begin
        dec.exec_fun = ALU_ADD;
        dec.data2    = imm_u;
        dec.rf_wen   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.exec_fun = ALU_ADD;
        dec.data1    = pc;
        dec.data2    = imm_u;
        dec.rf_wen   = 1'b1;
      end
      OPC_LOAD: begin
        dec.exec_fun = ALU_ADD;
        dec.data1    = rs1_data;
        dec.data2    = imm_i;
        dec.wb_sel   = WB_MEM;
        dec.rf_wen   = 1'b1;
        legal        = (funct3 == F3_LW);
      end
      OPC_STORE: begin
        dec.exec_fun   = ALU_ADD;
        dec.data1      = rs1_data;
        dec.data2      = imm_s;
        dec.store_data = rs2_data;
        dec.mem_wen    = 1'b1;
        legal          = (funct3 == F3_SW);
      end
      OPC_BRANCH: begin
        dec.data1     = rs1_data;
        dec.data2     = rs2_data;
        dec.br_target = pc + imm_b;
        dec.is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  dec.exec_fun = ALU_BEQ;
          F3_BNE:  dec.exec_fun = ALU_BNE;
          F3_BLT:  dec.exec_fun = ALU_BLT;
          F3_BGE:  dec.exec_fun = ALU_BGE;
          F3_BLTU: dec.exec_fun = ALU_BLTU;
          F3_BGEU: dec.exec_fun = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dec.exec_fun  = ALU_ADD;
        dec.data1     = pc;
        dec.data2     = imm_j;
        dec.br_target = pc + imm_j;
        dec.is_jump   = 1'b1;
        dec.wb_sel    = WB_PC4;
        dec.rf_wen    = 1'b1;
      end
      OPC_JALR: begin
        dec.exec_fun = ALU_JALR;
        dec.data1    = rs1_data;
        dec.data2    = imm_i;
        dec.is_jump  = 1'b1;
        dec.wb_sel   = WB_PC4;
        dec.rf_wen   = 1'b1;
        legal        = (funct3 == F3_JALR);
      end
      default: legal = 1'b0;
    endcase

    // Illegal words keep pc/rd for trap reporting but carry no side effects.
    if (!legal) begin
      dec         = idle_bundle();
      dec.pc      = pc;
      dec.rd_addr = rd;
      dec.illegal = 1'b1;
    end
    if (rd == 5'd0) dec.rf_wen = 1'b0;
  end

endmodule

// File: rtl/riscv_id_stage.sv
// RV32I instruction-decode stage: combinational decode of the offered instruction
// captured into a single valid/ready output register.
module riscv_id_stage
  import riscv_constants::*;
#(
  parameter int unsigned WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] pc,
  input  logic [WORD_LENGTH-1:0] inst,
  input  logic                   flush,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  input  logic [WORD_LENGTH-1:0] rs1_data,
  input  logic [WORD_LENGTH-1:0] rs2_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output EXEC_FUN                exec_fun,
  output logic [WORD_LENGTH-1:0] data1,
  output logic [WORD_LENGTH-1:0] data2,
  output logic [WORD_LENGTH-1:0] store_data,
  output logic [WORD_LENGTH-1:0] br_target,
  output logic [WORD_LENGTH-1:0] out_pc,
  output logic [4:0]             rd_addr,
  output logic                   rf_wen,
  output logic                   mem_wen,
  output logic                   is_branch,
  output logic                   is_jump,
  output logic                   illegal,
  output WB_SEL                  wb_sel
);

  id_bundle_t dec;
  id_bundle_t bundle_q;
  id_bundle_t bundle_d;
  logic       valid_q;
  logic       valid_d;

  riscv_decoder u_decoder (
    .inst     (inst),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .dec      (dec)
  );

  assign in_ready = !valid_q || out_ready;

  // An empty register always holds the idle bundle, so write enables stay low.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d  = 1'b0;
      bundle_d = idle_bundle();
    end else if (in_valid && in_ready) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (in_ready) begin
      valid_d  = 1'b0;
      bundle_d = idle_bundle();
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= idle_bundle();
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid  = valid_q;
  assign exec_fun   = bundle_q.exec_fun;
  assign wb_sel     = bundle_q.wb_sel;
  assign data1      = bundle_q.data1;
  assign data2      = bundle_q.data2;
  assign store_data = bundle_q.store_data;
  assign br_target  = bundle_q.br_target;
  assign out_pc     = bundle_q.pc;
  assign rd_addr    = bundle_q.rd_addr;
  assign rf_wen     = bundle_q.rf_wen;
  assign mem_wen    = bundle_q.mem_wen;
  assign is_branch  = bundle_q.is_branch;
  assign is_jump    = bundle_q.is_jump;
  assign illegal    = bundle_q.illegal;

endmodule
